// File: rtl/inst_sram_responder_if.sv
// -----------------------------------------------------------------------------
// inst_sram_responder_if
//   Bundles the instruction-fetch SRAM request and response signals.
//   master : the fetch stage. It drives en/wen/addr/wdata and receives the response.
//   slave  : inst_sram_responder. It receives requests and drives the response.
//
//   Request side
//     inst_sram_en       request valid
//     inst_sram_wen      byte write enables (0 = read)
//     inst_sram_addr     virtual byte address
//     inst_sram_wdata    write data
//   Response side
//     inst_sram_rvalid   response valid (reads only)
//     inst_sram_raddr    echo of the request address
//     inst_sram_rdata    word at addr
//     inst_sram_rdata_hi word at addr+4
//     inst_sram_rerr     misaligned or out-of-range request
// -----------------------------------------------------------------------------
interface inst_sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_rvalid;
  logic [31:0] inst_sram_raddr;
  logic [31:0] inst_sram_rdata;
  logic [31:0] inst_sram_rdata_hi;
  logic        inst_sram_rerr;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rvalid, inst_sram_raddr, inst_sram_rdata,
           inst_sram_rdata_hi, inst_sram_rerr
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rvalid, inst_sram_raddr, inst_sram_rdata,
           inst_sram_rdata_hi, inst_sram_rerr
  );
endinterface

// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
//   Word-organised instruction memory for dual-issue fetch. Each read returns
//   the word at addr and the word at addr+4 after a fixed LATENCY (1..4).
//
// Ports
//   clk    clock
//   rst    synchronous, active-high reset (clears pipeline and outputs only)
//   hold   freeze the response pipeline and outputs
//   flush  discard every in-flight response; the request this cycle is kept
//   bus    inst_sram_responder_if.slave (request in, response out)
//
// Handshake: there is no ready signal. A request is taken in any cycle with
// en=1 and (hold=0 or flush=1). While hold=1 and flush=0 the request is not
// taken and the requester keeps it stable. Each accepted read produces exactly
// one response, rvalid=1 for one cycle LATENCY cycles later, unless hold
// stretches it. Writes never produce a response. The only backpressure on
// responses is hold.
// -----------------------------------------------------------------------------
module inst_sram_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_PADDR = 32'h1FC0_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   flush,
  inst_sram_responder_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] data_hi;
  } resp_t;

  logic [31:0] mem [DEPTH];

  logic [31:0]           paddr;
  logic [31:0]           offset;
  logic                  in_range;
  logic                  aligned;
  logic                  addr_ok;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] idx_hi;
  logic                  hi_in_range;
  logic                  accept;
  logic                  acc_rd;
  logic                  acc_wr;
  resp_t                 new_resp;

  // Stage 0 is loaded in the accept cycle; stage LATENCY-1 drives the outputs.
  resp_t st_q [LATENCY];

  always_comb begin
    paddr       = {3'b000, bus.inst_sram_addr[28:0]};
    offset      = paddr - BASE_PADDR;
    // The upper offset bits must be zero, so addresses past the array are rejected.
    in_range    = (paddr >= BASE_PADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    aligned     = (bus.inst_sram_addr[1:0] == 2'b00);
    addr_ok     = in_range && aligned;
    idx         = offset[DEPTH_LOG2+1:2];
    idx_hi      = idx + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    // The last word has no successor. rdata_hi reads as zero and is not an error.
    hi_in_range = (idx != {DEPTH_LOG2{1'b1}});

    // flush overrides hold, so the redirect target is always taken.
    accept = bus.inst_sram_en && (!hold || flush);
    acc_rd = accept && (bus.inst_sram_wen == 4'b0000);
    acc_wr = accept && (bus.inst_sram_wen != 4'b0000) && addr_ok;

    new_resp         = '0;
    new_resp.valid   = acc_rd;
    new_resp.err     = !addr_ok;
    new_resp.addr    = bus.inst_sram_addr;
    if (addr_ok) begin
      new_resp.data    = mem[idx];
      new_resp.data_hi = hi_in_range ? mem[idx_hi] : 32'h0;
    end
  end

  // Array contents survive reset. Writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.inst_sram_wen[b]) begin
          mem[idx][8*b +: 8] <= bus.inst_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline. A stage loads payload only when valid data arrives, so
  // the output stage keeps its last response while rvalid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        st_q[i] <= '0;
      end
    end else if (flush || !hold) begin
      if (acc_rd) begin
        st_q[0] <= new_resp;
      end else begin
        st_q[0].valid <= 1'b0;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (!flush && st_q[i-1].valid) begin
          st_q[i] <= st_q[i-1];
        end else begin
          st_q[i].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.inst_sram_rvalid   = st_q[LATENCY-1].valid;
  assign bus.inst_sram_rerr     = st_q[LATENCY-1].err;
  assign bus.inst_sram_raddr    = st_q[LATENCY-1].addr;
  assign bus.inst_sram_rdata    = st_q[LATENCY-1].data;
  assign bus.inst_sram_rdata_hi = st_q[LATENCY-1].data_hi;

endmodule
